// File: rtl/inst_queue_if.sv
// rtl/inst_queue_if.sv - fetch/issue handshake bundle for the instruction queue
interface inst_queue_if #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
);
    logic             flush;
    logic             fetch_wen;
    logic [31:0]      fetch_inst;
    logic [31:0]      fetch_pc;
    logic [31:0]      fetch_pc_next;
    logic             issue_req;
    logic             iq_isfull;
    logic             iq_isempty;
    logic [PTR_W:0]   iq_count;
    logic [31:0]      iq_inst;
    logic [31:0]      iq_pc;
    logic [31:0]      iq_pc_next;
    logic             iq_rvalid;

    modport slave (
        input  flush, fetch_wen, fetch_inst, fetch_pc, fetch_pc_next, issue_req,
        output iq_isfull, iq_isempty, iq_count, iq_inst, iq_pc, iq_pc_next, iq_rvalid
    );

    modport master (
        output flush, fetch_wen, fetch_inst, fetch_pc, fetch_pc_next, issue_req,
        input  iq_isfull, iq_isempty, iq_count, iq_inst, iq_pc, iq_pc_next, iq_rvalid
    );
endinterface

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - show-ahead circular instruction FIFO between fetch and issue
// Optional same-cycle empty-queue bypass enabled by defining IQ_BYPASS_EN.
module inst_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    inst_queue_if.slave  iq
);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [31:0]      inst_q    [DEPTH];
    logic [31:0]      pc_q      [DEPTH];
    logic [31:0]      pc_next_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic empty;
    logic full;
    logic bypass;
    logic push;
    logic pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

`ifdef IQ_BYPASS_EN
    assign bypass = empty && iq.fetch_wen && !iq.flush && !rst;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed entry consumed in the same cycle never touches storage.
    assign push = iq.fetch_wen && !full && !iq.flush && !(bypass && iq.issue_req);
    assign pop  = iq.issue_req && !empty && !iq.flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (iq.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push && !pop)      count_d = count_q + CNT_ONE;
            else if (pop && !push) count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i]    <= '0;
                pc_q[i]      <= '0;
                pc_next_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push) begin
                inst_q[wr_ptr_q]    <= iq.fetch_inst;
                pc_q[wr_ptr_q]      <= iq.fetch_pc;
                pc_next_q[wr_ptr_q] <= iq.fetch_pc_next;
            end
        end
    end

    always_comb begin
        if (bypass) begin
            iq.iq_inst    = iq.fetch_inst;
            iq.iq_pc      = iq.fetch_pc;
            iq.iq_pc_next = iq.fetch_pc_next;
        end else begin
            iq.iq_inst    = inst_q[rd_ptr_q];
            iq.iq_pc      = pc_q[rd_ptr_q];
            iq.iq_pc_next = pc_next_q[rd_ptr_q];
        end
        iq.iq_rvalid = (!empty && !iq.flush) || bypass;
    end

    assign iq.iq_isfull  = full;
    assign iq.iq_isempty = empty;
    assign iq.iq_count   = count_q;
endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - self-checking bench for inst_queue against a queue-based model
module tb_inst_queue;
    localparam int DEPTH = 8;
`ifdef IQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc_next;
    } entry_t;

    typedef struct {
        bit          w;
        logic [31:0] inst;
        logic [31:0] pc;
        bit          q;
        bit          exp_v;
        int          exp_cnt;
        logic [31:0] exp_inst;
        logic [31:0] exp_pc;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    entry_t model[$];
    vec_t   vecs[7];

    inst_queue_if #(.DEPTH(DEPTH)) bus ();
    inst_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .iq(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit w, input logic [31:0] ins, input logic [31:0] p,
                         input logic [31:0] pn, input bit q, input bit f);
        rst               = r;
        bus.fetch_wen     = w;
        bus.fetch_inst    = ins;
        bus.fetch_pc      = p;
        bus.fetch_pc_next = pn;
        bus.issue_req     = q;
        bus.flush         = f;
    endtask

    // One cycle: drive at negedge, check combinational outputs against the model, then advance the model at posedge.
    task automatic step(input bit r, input bit w, input logic [31:0] ins, input logic [31:0] p,
                        input logic [31:0] pn, input bit q, input bit f);
        bit     byp;
        bit     exp_valid;
        bit     do_push;
        bit     do_pop;
        entry_t e;
        @(negedge clk);
        drive(r, w, ins, p, pn, q, f);
        #1;
        byp       = BYP && !r && !f && w && (model.size() == 0);
        exp_valid = ((model.size() != 0) && !f) || byp;
        chk("count",   32'(bus.iq_count),   32'(model.size()));
        chk("isfull",  32'(bus.iq_isfull),  32'(model.size() == DEPTH));
        chk("isempty", 32'(bus.iq_isempty), 32'(model.size() == 0));
        chk("rvalid",  32'(bus.iq_rvalid),  32'(exp_valid));
        if (exp_valid) begin
            if (byp) begin
                e.inst = ins; e.pc = p; e.pc_next = pn;
            end else begin
                e = model[0];
            end
            chk("head_inst",    bus.iq_inst,    e.inst);
            chk("head_pc",      bus.iq_pc,      e.pc);
            chk("head_pc_next", bus.iq_pc_next, e.pc_next);
        end
        @(posedge clk);
        if (r || f) begin
            model.delete();
        end else begin
            do_pop  = q && (model.size() != 0);
            do_push = w && (model.size() < DEPTH) && !(byp && q);
            if (do_pop) void'(model.pop_front());
            if (do_push) begin
                e.inst = ins; e.pc = p; e.pc_next = pn;
                model.push_back(e);
            end
        end
    endtask

    task automatic push_pc(input logic [31:0] p);
        step(1'b0, 1'b1, p ^ 32'h0000_0013, p, p + 32'd4, 1'b0, 1'b0);
    endtask

    task automatic pop1();
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        drive(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        model.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rvalid",  32'(bus.iq_rvalid),  32'd0);
        chk("rst_isempty", 32'(bus.iq_isempty), 32'd1);
        chk("rst_isfull",  32'(bus.iq_isfull),  32'd0);
        chk("rst_count",   32'(bus.iq_count),   32'd0);
        chk("rst_inst",    bus.iq_inst,         32'd0);
        chk("rst_pc",      bus.iq_pc,           32'd0);
        chk("rst_pc_next", bus.iq_pc_next,      32'd0);

        vecs[0] = '{1'b1, 32'h0000_0013, 32'h6000_0000, 1'b0, BYP,  0, 32'h0000_0013, 32'h6000_0000};
        vecs[1] = '{1'b1, 32'h0010_0093, 32'h6000_0004, 1'b0, 1'b1, 1, 32'h0000_0013, 32'h6000_0000};
        vecs[2] = '{1'b1, 32'h0020_0113, 32'h6000_0008, 1'b0, 1'b1, 2, 32'h0000_0013, 32'h6000_0000};
        vecs[3] = '{1'b0, 32'h0,         32'h0,         1'b1, 1'b1, 3, 32'h0000_0013, 32'h6000_0000};
        vecs[4] = '{1'b0, 32'h0,         32'h0,         1'b1, 1'b1, 2, 32'h0010_0093, 32'h6000_0004};
        vecs[5] = '{1'b0, 32'h0,         32'h0,         1'b1, 1'b1, 1, 32'h0020_0113, 32'h6000_0008};
        vecs[6] = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 0, 32'h0,         32'h0};
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(1'b0, vecs[i].w, vecs[i].inst, vecs[i].pc, vecs[i].pc + 32'd4, vecs[i].q, 1'b0);
            #1;
            chk($sformatf("vec%0d_rvalid", i),  32'(bus.iq_rvalid),  32'(vecs[i].exp_v));
            chk($sformatf("vec%0d_count", i),   32'(bus.iq_count),   32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_isempty", i), 32'(bus.iq_isempty), 32'(vecs[i].exp_cnt == 0));
            if (vecs[i].exp_v) begin
                chk($sformatf("vec%0d_inst", i),    bus.iq_inst,    vecs[i].exp_inst);
                chk($sformatf("vec%0d_pc", i),      bus.iq_pc,      vecs[i].exp_pc);
                chk($sformatf("vec%0d_pc_next", i), bus.iq_pc_next, vecs[i].exp_pc + 32'd4);
            end
            @(posedge clk);
        end

        // Fill, overflow without and with a concurrent pop, then drain.
        for (int i = 0; i < DEPTH; i++) push_pc(32'h6000_0000 + 32'(4 * i));
        step(1'b0, 1'b1, 32'hdead_0001, 32'h6000_0900, 32'h6000_0904, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'hdead_0002, 32'h6000_0a00, 32'h6000_0a04, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) pop1();
        idle();

        // Wrap-around of both pointers.
        for (int i = 0; i < DEPTH; i++) push_pc(32'h6000_0000 + 32'(4 * i));
        for (int i = 0; i < 5; i++) pop1();
        for (int i = 0; i < 5; i++) push_pc(32'h6000_0020 + 32'(4 * i));
        for (int i = 0; i < DEPTH; i++) pop1();
        idle();

        // Flush with concurrent push and pop, then a push right after.
        for (int i = 0; i < 4; i++) push_pc(32'h6000_0040 + 32'(4 * i));
        step(1'b0, 1'b1, 32'hbad0_0000, 32'h6000_0bad, 32'h6000_0bb1, 1'b1, 1'b1);
        push_pc(32'h6000_0080);
        pop1();
        idle();

        // Empty queue with simultaneous fetch and issue.
        step(1'b0, 1'b1, 32'h0000_0113, 32'h6000_0100, 32'h6000_0104, 1'b1, 1'b0);
        idle();
        chk("after_empty_issue_count", 32'(bus.iq_count), BYP ? 32'd0 : 32'd1);
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] p;
            p = 32'h6000_0000 + {$urandom_range(0, 16'hffff), 2'b00};
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 6), $urandom, p, p + 32'd4,
                 ($urandom_range(0, 9) < 5), ($urandom_range(0, 23) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
